// File: rtl/alu_pkg.sv
// Shared types for the ALU operand loader: FSM states, opsel codes, flag bundle
// and the reserved-command decode.
package alu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        EXEC,
        HOLD
    } loader_state_t;

    localparam logic [2:0] OP_0 = 3'b000;
    localparam logic [2:0] OP_1 = 3'b001;
    localparam logic [2:0] OP_2 = 3'b010;
    localparam logic [2:0] OP_3 = 3'b011;
    localparam logic [2:0] OP_4 = 3'b100;
    localparam logic [2:0] OP_5 = 3'b101;
    localparam logic [2:0] OP_6 = 3'b110;

    typedef struct packed {
        logic c;
        logic z;
        logic o;
        logic s;
    } flags_t;

    // Mode 0 has seven opcodes (111 unused); mode 1 only five (101..111 unused).
    function automatic logic is_reserved(input logic mode, input logic [2:0] opsel);
        return mode ? (opsel >= OP_5) : (opsel == 3'b111);
    endfunction

endpackage

// File: rtl/alu_operand_loader_if.sv
// Host-side streams of the ALU operand loader: command/operand beat input and
// result output, each a valid/ready pair.
interface alu_operand_loader_if #(
    parameter int DWIDTH = 128,
    parameter int BWIDTH = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [BWIDTH-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_result;
    logic [3:0]        out_flags;
    logic              out_err;
    logic              out_sticky_o;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_err, out_sticky_o
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_err, out_sticky_o
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Deserialises a command and two DWIDTH operands from BWIDTH beats, drives the ALU,
// then captures and holds its result. Optional sticky overflow: ALU_STICKY_OVF_EN.
//
// state  | meaning
// IDLE   | waiting for command beat
// LOAD_A | collecting operand 1 beats, LSW first
// LOAD_B | collecting operand 2 beats, LSW first
// EXEC   | one settle cycle, ALU inputs stable, result captured at its end
// HOLD   | result presented until consumed
module alu_operand_loader
    import alu_pkg::*;
#(
    parameter int DWIDTH = 128,
    parameter int BWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_operand_loader_if.slave bus,
    output logic [DWIDTH-1:0] alu_op1,
    output logic [DWIDTH-1:0] alu_op2,
    output logic [2:0]        alu_opsel,
    output logic              alu_mode,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic              alu_c,
    input  logic              alu_z,
    input  logic              alu_o,
    input  logic              alu_s
);

    // DWIDTH must be a whole number of beats.
    localparam int BEATS = DWIDTH / BWIDTH;
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    loader_state_t     state;
    loader_state_t     state_next;
    logic [CW-1:0]     cnt;
    logic              err;
    logic              in_ready;
    logic              beat_fire;
    logic              last_beat;
    logic              out_fire;
    logic              out_valid;
    logic [DWIDTH-1:0] out_result;
    logic [3:0]        out_flags;
    logic              out_err;
    flags_t            alu_flags;
    logic              unused_in;

    assign in_ready  = rst_n && (state == IDLE || state == LOAD_A || state == LOAD_B);
    assign beat_fire = bus.in_valid && in_ready;
    assign last_beat = (cnt == LAST_BEAT);
    assign out_fire  = out_valid && bus.out_ready;
    assign alu_flags = '{c: alu_c, z: alu_z, o: alu_o, s: alu_s};

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_result = out_result;
    assign bus.out_flags  = out_flags;
    assign bus.out_err    = out_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beat_fire) state_next = LOAD_A;
            LOAD_A:  if (beat_fire && last_beat) state_next = LOAD_B;
            LOAD_B:  if (beat_fire && last_beat) state_next = EXEC;
            EXEC:    state_next = HOLD;
            HOLD:    if (out_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand registers are not cleared between operations; each beat overwrites its slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            err        <= 1'b0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_opsel  <= '0;
            alu_mode   <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            out_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (beat_fire) begin
                        alu_opsel <= bus.in_data[2:0];
                        alu_mode  <= bus.in_data[3];
                        err       <= is_reserved(bus.in_data[3], bus.in_data[2:0]);
                        cnt       <= '0;
                    end
                end
                LOAD_A: begin
                    if (beat_fire) begin
                        alu_op1[cnt*BWIDTH +: BWIDTH] <= bus.in_data;
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                LOAD_B: begin
                    if (beat_fire) begin
                        alu_op2[cnt*BWIDTH +: BWIDTH] <= bus.in_data;
                        cnt <= last_beat ? '0 : cnt + 1'b1;
                    end
                end
                EXEC: begin
                    out_result <= err ? '0 : alu_result;
                    out_flags  <= err ? 4'b0000 : alu_flags;
                    out_err    <= err;
                    out_valid  <= 1'b1;
                end
                HOLD: begin
                    if (out_fire) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_STICKY_OVF_EN
    logic sticky_o;

    // A clearing command and a later overflow in the same op leave the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_o <= 1'b0;
        end else if (state == IDLE && beat_fire && bus.in_data[4]) begin
            sticky_o <= 1'b0;
        end else if (state == EXEC && !err) begin
            sticky_o <= sticky_o | alu_o;
        end
    end

    assign bus.out_sticky_o = sticky_o;
    assign unused_in = ^bus.in_data[BWIDTH-1:5];
`else
    assign bus.out_sticky_o = 1'b0;
    assign unused_in = ^bus.in_data[BWIDTH-1:4];
`endif

endmodule

// File: tb/tb_alu_operand_loader.sv
// Randomised scoreboard bench for alu_operand_loader with a behavioural ALU stub;
// honours ALU_STICKY_OVF_EN when defined.
module tb_alu_operand_loader;

`ifdef ALU_STICKY_OVF_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    typedef struct {
        logic [127:0] r;
        logic [3:0]   f;
        logic         e;
        logic         s;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic [127:0] alu_op1, alu_op2, alu_result;
    logic [2:0]   alu_opsel;
    logic         alu_mode, alu_c, alu_z, alu_o, alu_s;

    int   checks = 0;
    int   failures = 0;
    int   ready_ctl = 2;   // 0 random, 1 force low, 2 force high
    logic exp_sticky = 1'b0;
    exp_t sb[$];

    alu_operand_loader_if #(.DWIDTH(128), .BWIDTH(32)) bus ();

    alu_operand_loader #(.DWIDTH(128), .BWIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_opsel  (alu_opsel),
        .alu_mode   (alu_mode),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .alu_o      (alu_o),
        .alu_s      (alu_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench ALU: returns {c,z,o,s,result}; overflow is reported as unsigned carry/borrow.
    function automatic logic [131:0] ref_alu(input logic [127:0] a, input logic [127:0] b,
                                             input logic [2:0] op, input logic m);
        logic [128:0] w;
        logic [127:0] r;
        logic c, o;
        w = '0; r = '0; c = 1'b0; o = 1'b0;
        if (!m) begin
            case (op)
                3'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[127:0]; c = w[128]; o = c; end
                3'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[127:0]; c = w[128]; o = c; end
                3'd2: r = a & b;
                3'd3: r = a | b;
                3'd4: r = a ^ b;
                3'd5: begin r = a << 1; c = a[127]; end
                3'd6: begin r = a >> 1; c = a[0]; end
                default: begin r = ~a; c = 1'b1; o = 1'b1; end
            endcase
        end else begin
            case (op)
                3'd0: begin w = {1'b0, b} - {1'b0, a}; r = w[127:0]; c = w[128]; o = c; end
                3'd1: r = ~a;
                3'd2: begin w = {1'b0, a} + 129'd1; r = w[127:0]; c = w[128]; o = c; end
                3'd3: r = a & ~b;
                3'd4: r = a ^ ~b;
                default: begin r = ~a; c = 1'b1; o = 1'b1; end
            endcase
        end
        return {c, (r == 128'd0), o, r[127], r};
    endfunction

    always_comb begin
        {alu_c, alu_z, alu_o, alu_s, alu_result} = ref_alu(alu_op1, alu_op2, alu_opsel, alu_mode);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Consumer handshake driver.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_ctl)
                1:       bus.out_ready = 1'b0;
                2:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom % 4) != 0;
            endcase
        end
    end

    // Monitor: every consumed result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 128'(bus.out_valid), 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_result", bus.out_result, e.r);
                check("out_flags", 128'(bus.out_flags), 128'(e.f));
                check("out_err", 128'(bus.out_err), 128'(e.e));
                check("out_sticky_o", 128'(bus.out_sticky_o), 128'(e.s));
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input int gap);
        int guard;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        guard = 0;
        while (!bus.in_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) check("in_ready_timeout", 128'(bus.in_ready), 128'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int gap);
        return (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    endfunction

    task automatic run_op(input logic [31:0] cmd, input logic [127:0] a, input logic [127:0] b,
                          input int gap);
        exp_t e;
        logic [131:0] res;
        send_beat(cmd, pick_gap(gap));
        if (STICKY && cmd[4]) exp_sticky = 1'b0;
        for (int i = 0; i < 4; i++) send_beat(a[i*32 +: 32], pick_gap(gap));
        for (int i = 0; i < 4; i++) send_beat(b[i*32 +: 32], pick_gap(gap));
        e.e = cmd[3] ? (cmd[2:0] >= 3'd5) : (cmd[2:0] == 3'd7);
        res = ref_alu(a, b, cmd[2:0], cmd[3]);
        e.r = e.e ? 128'd0 : res[127:0];
        e.f = e.e ? 4'd0 : res[131:128];
        if (STICKY && !e.e) exp_sticky = exp_sticky | res[129];
        e.s = exp_sticky;
        sb.push_back(e);
        // One cycle after the last beat: EXEC with operands fully assembled.
        check("exec_op1", alu_op1, a);
        check("exec_op2", alu_op2, b);
        check("exec_opsel", 128'(alu_opsel), 128'(cmd[2:0]));
        check("exec_mode", 128'(alu_mode), 128'(cmd[3]));
        check("exec_out_valid", 128'(bus.out_valid), 128'd0);
        @(posedge clk);
        #1;
        check("latency_out_valid", 128'(bus.out_valid), 128'd1);
    endtask

    task automatic wait_out_valid();
        int guard;
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) check("out_valid_timeout", 128'(bus.out_valid), 128'd1);
    endtask

    initial begin
        logic [127:0] held_r;
        logic [3:0]   held_f;
        int           guard;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_alu_op1", alu_op1, 128'd0);
        check("rst_alu_op2", alu_op2, 128'd0);
        check("rst_opsel_mode", 128'({alu_opsel, alu_mode}), 128'd0);
        check("rst_out_result", bus.out_result, 128'd0);
        check("rst_out_flags", 128'({bus.out_flags, bus.out_err, bus.out_sticky_o}), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 128'(bus.in_ready), 128'd1);

        // Basic add, then all-ones + 1 (carry/zero/overflow).
        ready_ctl = 2;
        run_op(32'h0, 128'd1, 128'd1, 0);
        run_op(32'h0, {128{1'b1}}, 128'd1, 0);

        // Consumer stalls five cycles in HOLD.
        ready_ctl = 1;
        run_op(32'h4, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 128'hF0F0, 0);
        wait_out_valid();
        @(negedge clk);
        held_r = bus.out_result;
        held_f = bus.out_flags;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 128'(bus.out_valid), 128'd1);
            check("hold_result_stable", bus.out_result, held_r);
            check("hold_flags_stable", 128'(bus.out_flags), 128'(held_f));
            check("hold_in_ready", 128'(bus.in_ready), 128'd0);
        end
        ready_ctl = 2;
        guard = 0;
        while (bus.out_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("hold_release_valid", 128'(bus.out_valid), 128'd0);
        check("after_hold_in_ready", 128'(bus.in_ready), 128'd1);

        // in_valid toggling every cycle while loading.
        ready_ctl = 0;
        run_op(32'h3, 128'h0123456789ABCDEF_0123456789ABCDEF, 128'h89AB_CDEF_0000_0001, 1);

        // Reserved command: mode=1 opsel=111.
        run_op(32'h0F, 128'hDEAD_BEEF, 128'h1234, 0);
        run_op(32'h0D, 128'h55, 128'h66, 0);

        // Reset after the 2nd op2 beat, then a clean full op.
        wait_out_valid();
        repeat (6) @(negedge clk);
        send_beat(32'h1, 0);
        for (int i = 0; i < 4; i++) send_beat(32'hAAAA_0000 + i, 0);
        send_beat(32'hBBBB_0000, 0);
        send_beat(32'hBBBB_0001, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("midop_rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("midop_rst_alu_op1", alu_op1, 128'd0);
        exp_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h1, 128'h7, 128'h3, 0);

        // Reset while holding a result drops out_valid at once.
        ready_ctl = 1;
        run_op(32'h2, 128'hFFFF, 128'h0F0F, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("hold_rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("hold_rst_out_result", bus.out_result, 128'd0);
        if (sb.size() > 0) void'(sb.pop_back());
        exp_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ready_ctl = 0;

        // Overflow sets sticky; a bit4 command clears it.
        run_op(32'h0, {128{1'b1}}, 128'd2, 0);
        run_op(32'h0, 128'd5, 128'd6, 0);
        run_op(32'h10, 128'd5, 128'd6, 0);

        for (int n = 0; n < 24; n++) begin
            logic [31:0]  cmd;
            logic [127:0] a, b;
            cmd = {$urandom} & 32'hFFFF_FFDF;
            if ((cmd[7:5] % 3) != 0) cmd[3:0] = cmd[3] ? {1'b1, 3'($urandom_range(0, 4))}
                                                       : {1'b0, 3'($urandom_range(0, 6))};
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            if (n % 5 == 0) a = {128{1'b1}};
            run_op(cmd, a, b, -1);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("scoreboard_drained", 128'(sb.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
